// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment check applied when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Also rejects the illegal size, so one call decides whether memory is touched.
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
// master = execute stage (initiator), slave = load_store_unit.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for a 32-bit word: extracts and extends load data, and
// merges right-justified store data into an existing word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_load = i_word;
        case (i_size)
            SZ_B:    o_load = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_load = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_B:    o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            SZ_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge = i_wdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller for a word-wide data memory.
// Sub-word stores use read-modify-write; misaligned/illegal requests never reach memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);
    state_e                r_state;
    logic                  r_we;
    logic                  r_unsigned;
    size_e                 r_size;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic                  w_accept;
    logic                  w_err;
    size_e                 w_size;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merge;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_size   = size_e'(bus.req_size);
    assign w_err    = misaligned(w_size, bus.req_addr[1:0]);

    lsu_byte_lane u_lane (
        .i_word     (i_mem_rd_data),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    // Control and every register that feeds an output pin is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mem_addr <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mem_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_rdata    <= '0;
                        r_err      <= w_err;
                        if (w_err)
                            r_state <= RESP;
                        else if (bus.req_we && (w_size == SZ_W))
                            r_state <= WR;
                        else
                            r_state <= RD;
                    end
                end
                RD: begin
                    if (r_we) begin
                        r_state <= WR;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= RESP;
                    end
                end
                WR:      r_state <= RESP;
                default: if (bus.resp_ready) r_state <= IDLE;
            endcase
        end
    end

    // Request fields are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= w_size;
            r_unsigned <= bus.req_unsigned;
            r_off      <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata;
            r_wr_data  <= bus.req_wdata;
        end else if (r_state == RD) begin
            r_wr_data <= w_merge;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    assign o_mem_wr_en   = (r_state == WR);
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wr_data = (r_state == WR) ? r_wr_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-organised memory model and an
// expected-response queue filled at request time and drained at response time.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [7:0]  wmask;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        mem_init = 1'b1;
    logic        wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [64];
    int          tests    = 0;
    int          fails    = 0;
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    exp_t        sb[$];

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .o_mem_wr_en   (wr_en),
        .o_mem_addr    (mem_addr),
        .o_mem_wr_data (mem_wdata),
        .i_mem_rd_data (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
        end else if (wr_en) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_count           <= wr_count + 1;
            last_wr_addr       <= mem_addr;
            last_wr_data       <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic [7:0] exp_wmask, input int hold);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          wr0;
        logic [7:0]  wmask;
        logic [31:0] held_rdata;
        logic        held_err;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.wmask = exp_wmask;
        sb.push_back(e);
        @(negedge clk);
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        wr0              = wr_count;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat   = 0;
        wmask = 8'h0;
        do begin
            @(negedge clk);
            lat++;
            if (lat < 8) wmask[lat] = wr_en;
        end while (!bus.resp_valid && lat < 10);
        got = sb.pop_front();
        check({tag, "/latency"}, 32'(lat), 32'(got.lat));
        check({tag, "/rdata"}, bus.resp_rdata, got.rdata);
        check({tag, "/err"}, 32'(bus.resp_err), 32'(got.err));
        check({tag, "/wr_cycles"}, 32'(wmask), 32'(got.wmask));
        held_rdata = bus.resp_rdata;
        held_err   = bus.resp_err;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "/hold_rdata"}, bus.resp_rdata, held_rdata);
            check({tag, "/hold_err"}, 32'(bus.resp_err), 32'(held_err));
            check({tag, "/hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check({tag, "/idle_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "/idle_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "/write_count"}, 32'(wr_count - wr0), 32'($countones(got.wmask)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "/resp_rdata"}, bus.resp_rdata, 32'h0);
        check({tag, "/resp_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, "/mem_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "/mem_addr"}, mem_addr, 32'h0);
        check({tag, "/mem_wr_data"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        mem_init = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        // Loads from the preloaded word 0xDEADBEEF at 0x10
        do_txn("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 8'h00, 0);
        do_txn("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000BE, 1'b0, 2, 8'h00, 0);
        do_txn("lh_10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 8'h00, 0);

        // Half store read-modify-write: write only in cycle 2
        do_txn("sh_12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 32'h0, 1'b0, 3, 8'h04, 0);
        check("sh_12/wr_addr", last_wr_addr, 32'h10);
        check("sh_12/wr_data", last_wr_data, 32'h1234BEEF);
        do_txn("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2, 8'h00, 0);
        do_txn("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0, 2, 8'h00, 0);

        // Error requests respond in cycle 1 and never write
        do_txn("sw_15",  1'b1, 2'b10, 1'b0, 32'h15, 32'hCAFEF00D, 32'h0, 1'b1, 1, 8'h00, 0);
        do_txn("ill_10", 1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b1, 1, 8'h00, 0);
        do_txn("lh_11",  1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 8'h00, 0);
        check("errs/mem10", mem[4], 32'h1234BEEF);

        // Word load with the response back-pressured for 3 cycles
        do_txn("lw_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2, 8'h00, 3);

        // Word store writes in cycle 1, then sub-word accesses on the new word
        do_txn("sw_20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, 2, 8'h02, 0);
        check("sw_20/wr_data", last_wr_data, 32'h0BADF00D);
        do_txn("lhu_22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h00000BAD, 1'b0, 2, 8'h00, 0);
        do_txn("lb_20",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0000000D, 1'b0, 2, 8'h00, 0);
        do_txn("lb_21",  1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 8'h00, 0);
        do_txn("sb_21",  1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFA5, 32'h0, 1'b0, 3, 8'h04, 0);
        check("sb_21/wr_addr", last_wr_addr, 32'h20);
        check("sb_21/wr_data", last_wr_data, 32'h0BADA50D);
        do_txn("lw_20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0BADA50D, 1'b0, 2, 8'h00, 0);

        // Reset asserted while a byte store sits in RD
        wr_before = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h00000077;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_rd/mem_addr", mem_addr, 32'h10);
        check("rst_rd/req_ready", 32'(bus.req_ready), 32'd0);
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_held");
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        repeat (2) @(negedge clk);
        check("rst/mem10", mem[4], 32'h1234BEEF);
        check("rst/write_count", 32'(wr_count - wr_before), 32'd0);
        check_reset_outputs("rst_after");

        do_txn("lbu_post", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0, 2, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access controller for the RISC-V CPU; sits between the core's execute stage and the word-organised `data_mem`. It accepts one load or store per handshake. It performs byte/halfword/word accesses with sign or zero extension. Because `data_mem` writes whole words only, sub-word stores are done as read-modify-write. Misaligned or illegal-size requests are flagged and never touch memory.

## Interface
- Reset is asynchronous and active-low; one clock.
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width; the design supports only 32 (4 byte lanes).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle with `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend loads (ignored for word and stores).
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed.
- `resp_rdata` out DATA_WIDTH: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned address or illegal size.
- `mem_wr_en` out 1: to `data_mem` write enable.
- `mem_addr` out ADDR_WIDTH: word-aligned, bits[1:0] always 00.
- `mem_wr_data` out DATA_WIDTH: full word to write.
- `mem_rd_data` in DATA_WIDTH: combinational read data for `mem_addr`.

## Operation
- FSM states are IDLE, RD, WR, RESP. `req_ready` = (state == IDLE).
- On accept, register `we`, `size`, `unsigned`, `addr` and `wdata`.
- Error check on accept:
  - size 11 → error.
  - half with addr[0]=1 → error.
  - word with addr[1:0]≠00 → error.
- State transitions from IDLE on accept:
  - Error → RESP with `resp_err`=1 and `resp_rdata`=0.
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RD.
- RD: `mem_addr` = {addr[31:2],00}; sample `mem_rd_data` at end of cycle.
  - Load: lane-select by addr[1:0], sign- or zero-extend into `resp_rdata`, then → RESP.
  - Sub-word store: capture old word, then → WR.
- WR: `mem_wr_en`=1 for exactly this one cycle.
  - `mem_wr_data` = old word with the addressed byte or half replaced by `wdata[7:0]` / `wdata[15:0]`; full `wdata` for a word store.
  - Then → RESP.
- RESP: `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until `resp_ready`; on `resp_valid & resp_ready` → IDLE.
- `mem_wr_en` is 0 in every state except WR. No memory access occurs for error requests.
- Reset value of all outputs is 0 except `req_ready`: state is IDLE, so `req_ready` reads 1. Requests while `rst_n`=0 are ignored.
- Reset mid-operation: the transaction is abandoned, `mem_wr_en` drops asynchronously, and no partial write occurs unless the WR edge already passed.

## Timing
- Cycle 0 = accept edge. First `resp_valid` cycle:
  - Load: cycle 2.
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
  - Error: cycle 1.
- Minimum spacing between accepts is 3, 3, 4 and 2 cycles respectively (includes the RESP handshake cycle with `resp_ready`=1).
- Throughput is one transaction in flight; no pipelining and no request buffering.
- `mem_addr` is registered and stable throughout RD and WR. RD→WR of a read-modify-write keeps the same address.

## Structure
- Package `lsu_pkg`:
  - `size_e` enum: SZ_B, SZ_H, SZ_W, SZ_ILL.
  - `state_e` enum: IDLE, RD, WR, RESP.
  - `misaligned()` function.
- Sub-module `lsu_byte_lane`: combinational; takes a word, addr[1:0], size and unsigned. It outputs the extracted/extended load value and the merged store word. Instantiated once.

## Test plan
Preload `data_mem` word at 0x10 = 0xDEADBEEF.
- Load byte signed at 0x13 → `resp_rdata`=0xFFFFFFDE, `resp_err`=0, `resp_valid` at cycle 2, `mem_wr_en` never 1.
- Load byte unsigned at 0x11 → 0x000000BE. Load half signed at 0x10 → 0xFFFFBEEF.
- Store half 0x00001234 at 0x12 → RD in cycle 1, `mem_wr_en`=1 only in cycle 2 with `mem_wr_data`=0x1234BEEF at `mem_addr` 0x10, `resp_valid` in cycle 3. A following word load at 0x10 returns 0x1234BEEF.
- Store word at 0x15 → `resp_err`=1 at cycle 1, `resp_rdata`=0, no `mem_wr_en`. Same result for size 11 at 0x10.
- Word load with `resp_ready` held 0 for 3 cycles → `resp_valid`, `resp_rdata` and `req_ready`=0 stable throughout; return to IDLE the cycle after `resp_ready`=1.
- Assert `rst_n`=0 during RD of a byte store → no `mem_wr_en` pulse, memory unchanged, all outputs 0 except `req_ready`=1.
